// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared opcode/state encodings and default latencies for the MDU issue controller.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MULBUSY = 2'd1,
    ST_DIVBUSY = 2'd2
  } mdu_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_write_op(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Codes 9..15 fall outside the MD class and behave like NONE.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MFLO);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline-side bundle of the MDU issue controller: E/D-stage inputs and MDU strobes.
interface mdu_issue_ctrl_if;
  logic       req;
  logic       e_valid;
  logic [3:0] e_op;
  logic       d_is_md;
  logic       md_start;
  logic       md_write;
  logic [3:0] md_op;
  logic       busy;
  logic       done;
  logic       stall;
  logic       proto_err;

  modport master (
    output req, e_valid, e_op, d_is_md,
    input  md_start, md_write, md_op, busy, done, stall, proto_err
  );

  modport slave (
    input  req, e_valid, e_op, d_is_md,
    output md_start, md_write, md_op, busy, done, stall, proto_err
  );
endinterface

// File: rtl/mdu_issue_ctrl_busy_cnt.sv
// Loadable down-counter timing an MDU operation; zero marks the final busy cycle.
module mdu_busy_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             active
);

  logic [CNT_W-1:0] count_reg;
  logic             active_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      count_reg  <= load_val;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (count_reg != '0) count_reg <= count_reg - 1'b1;
      else                 active_reg <= 1'b0;
    end
  end

  assign zero   = (count_reg == '0);
  assign active = active_reg;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU sequencer: issue strobes, busy countdown, D-stage stall, sticky protocol error.
// Optional MDU_ISSUE_PERF_EN adds free-running stall/issue counters.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mdu_issue_ctrl_if.slave bus
`ifdef MDU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_issue
`endif
);

  // Counter starts at latency-1 so that busy spans exactly the latency.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

  mdu_state_e       state_reg, state_next;
  logic             busy;
  logic             issue_ok;
  logic             start;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             cnt_active;
  logic             proto_err_reg;

  mdu_busy_cnt #(.CNT_W(CNT_W)) u_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero),
    .active   (cnt_active)
  );

  assign busy     = (state_reg != ST_IDLE);
  // Reset gates the strobes so they read low while reset is held.
  assign issue_ok = reset & bus.e_valid & ~bus.req & ~busy;
  assign start    = issue_ok & (is_mul_op(bus.e_op) | is_div_op(bus.e_op));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          if (is_mul_op(bus.e_op)) begin
            state_next   = ST_MULBUSY;
            cnt_load_val = MUL_LOAD;
          end else begin
            state_next   = ST_DIVBUSY;
            cnt_load_val = DIV_LOAD;
          end
        end
      end
      ST_MULBUSY, ST_DIVBUSY: begin
        if (cnt_zero) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        proto_err_reg <= 1'b0;
    else if (bus.e_valid && is_md_op(bus.e_op) && busy) proto_err_reg <= 1'b1;
  end

  assign bus.md_start  = start;
  assign bus.md_write  = issue_ok & is_write_op(bus.e_op);
  assign bus.md_op     = bus.e_op;
  assign bus.busy      = busy;
  assign bus.done      = busy & cnt_active & cnt_zero;
  assign bus.stall     = bus.d_is_md & (busy | start);
  assign bus.proto_err = proto_err_reg;

`ifdef MDU_ISSUE_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_issue_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_reg <= '0;
      perf_issue_reg <= '0;
    end else begin
      if (bus.stall) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (start)     perf_issue_reg <= perf_issue_reg + 32'd1;
    end
  end

  assign perf_stall = perf_stall_reg;
  assign perf_issue = perf_issue_reg;
`endif

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequences the multiply/divide unit (MDU) in the pipelined MIPS core. Sits in the E stage, between the decoded E-stage instruction and the MDU.
- Issues start and HI/LO write strobes, and owns the busy countdown (multiply/divide latency).
- Produces the D-stage stall for any MD-class instruction that would collide with an in-flight operation.
- Suppresses issue when an exception/interrupt request is pending.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu issue (≥1)
- DIV_CYC, 10, busy cycles after a div/divu issue (≥1)
- CNT_W, 4, countdown width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  exception/interrupt request; blocks issue this cycle
- e_valid  in  1  E-stage instruction valid
- e_op  in  4  E-stage MD opcode (package encoding)
- d_is_md  in  1  D-stage instruction is MD-class (mult..mflo)
- md_start  out  1  start strobe to MDU (comb)
- md_write  out  1  mthi/mtlo write strobe to MDU (comb)
- md_op  out  4  opcode to MDU, equals e_op
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on the last busy cycle
- stall  out  1  freeze F/D, bubble E
- proto_err  out  1  sticky: MD op presented in E while busy

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, proto_err=0; busy=done=stall=md_start=md_write=0 combinationally.
- States: IDLE, MULBUSY, DIVBUSY. busy = (state != IDLE).
- issue_ok = e_valid & ~req & (state==IDLE).
- md_start = issue_ok & e_op ∈ {MULT, MULTU, DIV, DIVU}.
- md_write = issue_ok & e_op ∈ {MTHI, MTLO}.
- MFHI/MFLO/NONE never strobe.
- IDLE, md_start with mult-class: next state MULBUSY, count ← MULT_CYC-1. Div-class: next state DIVBUSY, count ← DIV_CYC-1.
- MULBUSY/DIVBUSY:
  - count≠0: count decrements.
  - count==0: done=1 and next state IDLE.
  - busy therefore lasts exactly MULT_CYC/DIV_CYC cycles, starting the edge after md_start.
- Back-to-back: a new start is accepted in the first IDLE cycle after done (no dead cycle).
- stall = d_is_md & (busy | md_start). Covers the same-cycle E-issue/D-read hazard.
- Non-MD D-stage instructions never stall.
- req:
  - Masks md_start/md_write in the same cycle.
  - Does not abort an in-flight operation; the countdown continues.
  - req during busy has no effect on state.
- proto_err: set at the edge where e_valid & e_op ∈ {MULT..MFLO} & busy. Held until reset. The op is ignored (no strobe).
- Simultaneous done and d_is_md: stall still 1 that cycle (busy still 1); it releases the next cycle.
- Reset mid-operation returns to IDLE immediately; no done pulse.
- Opcodes 9..15 are treated as NONE.

Optional Feature:
- Macro: MDU_ISSUE_PERF_EN
- With the macro: adds outputs perf_stall [31:0] and perf_issue [31:0].
  - perf_stall counts cycles with stall=1.
  - perf_issue counts md_start pulses.
  - Both wrap at 2^32 and clear on reset.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mdu_pkg:
  - 4-bit op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - State encoding: IDLE=0, MULBUSY=1, DIVBUSY=2.
  - Default latency constants.
- One sub-module, mdu_busy_cnt: loadable down-counter with load value, load strobe, zero flag and active flag.
- The FSM, strobes and stall logic stay in the top level.

Test Plan:
- MULT issue: e_valid=1, e_op=1, req=0 in IDLE -> md_start=1 that cycle; busy=1 for 5 cycles; done on the 5th; IDLE next.
- DIVU then MFLO in D: issue DIVU with d_is_md=1 held -> stall=1 on the issue cycle plus 10 busy cycles; stall=0 on the following cycle.
- req masking: e_op=3 with req=1 -> md_start=0, busy stays 0. Same op next cycle with req=0 -> issues.
- MTHI while idle with d_is_md=0 -> md_write=1, md_start=0, busy=0, stall=0.
- Protocol violation: during MULBUSY present e_valid=1, e_op=2 -> no strobe, proto_err=1 sticky. Countdown unaffected.
- Reset mid-DIV (cycle 4 of 10) -> state IDLE, busy=0, done=0, proto_err=0 immediately. With MDU_ISSUE_PERF_EN, perf_stall and perf_issue read 0.
